// File: rtl/spinn_aer_if_dump_buf_if.sv
// Valid/ready packet channel between the AER mapper, the dump buffer and the SpiNNaker link TX.
// The master drives data/vld, and the slave answers with rdy.
interface spinn_aer_if_dump_buf_if #(
    parameter int unsigned PKT_BITS = 72
);
    logic [PKT_BITS-1:0] data;
    logic                vld;
    logic                rdy;

    modport master (output data, output vld, input rdy);
    modport slave  (input data, input vld, output rdy);
endinterface

// File: rtl/spinn_aer_if_dump_buf.sv
// This buffer sits between the AER mapper and the SpiNNaker link TX and uses a FWFT FIFO.
// It switches to dump mode after a sustained link stall, then discards and counts AER events.
module spinn_aer_if_dump_buf #(
    parameter int unsigned PKT_BITS       = 72,
    parameter int unsigned FIFO_ADDR_BITS = 2,
    parameter int unsigned DUMP_CNT       = 31,
    parameter int unsigned EXIT_CNT       = 1,
    parameter int unsigned CNT_BITS       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      go_i,
    input  logic                      drop_clr_i,
    output logic                      dump_mode_o,
    output logic [CNT_BITS-1:0]       drop_cnt_o,
    output logic [FIFO_ADDR_BITS:0]   fifo_level_o,
    spinn_aer_if_dump_buf_if.slave    mpkt,
    spinn_aer_if_dump_buf_if.master   ipkt
);
    localparam int unsigned DEPTH = 2 ** FIFO_ADDR_BITS;
    localparam int unsigned BW    = $clog2(DUMP_CNT + 1);
    localparam int unsigned EW    = $clog2(EXIT_CNT + 1);
    localparam logic [BW-1:0]             BUSY_LOAD  = BW'(DUMP_CNT);
    localparam logic [EW-1:0]             EXIT_LAST  = EW'(EXIT_CNT - 1);
    localparam logic [FIFO_ADDR_BITS:0]   FULL_LEVEL = (FIFO_ADDR_BITS + 1)'(DEPTH);

    typedef enum logic {IDLE, DUMP} state_e;

    state_e                    state_q;
    logic                      dump_mode_q;
    logic [BW-1:0]             busy_ctr_q, busy_ctr_d;
    logic [EW-1:0]             exit_ctr_q;
    logic [PKT_BITS-1:0]       mem_q [DEPTH];
    logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_BITS:0]   level_q, level_d;
    logic [CNT_BITS-1:0]       drop_cnt_q, drop_cnt_d;
    logic                      full, wr_en, rd_en, drop, busy;

    // mpkt.rdy depends only on go_i and registered state, so no path runs from ipkt.rdy to the AER side.
    assign full     = (level_q == FULL_LEVEL);
    assign mpkt.rdy = !go_i || dump_mode_q || !full;
    assign wr_en    = mpkt.vld && mpkt.rdy && go_i && !dump_mode_q;
    assign drop     = mpkt.vld && mpkt.rdy && (!go_i || dump_mode_q);
    assign ipkt.vld = (level_q != '0);
    assign ipkt.data = mem_q[rd_ptr_q];
    assign rd_en    = ipkt.vld && ipkt.rdy;
    assign busy     = ipkt.vld && !ipkt.rdy;

    assign dump_mode_o  = dump_mode_q;
    assign drop_cnt_o   = drop_cnt_q;
    assign fifo_level_o = level_q;

    always_comb begin
        wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d    = level_q;
        if (wr_en && !rd_en) level_d = level_q + 1'b1;
        if (rd_en && !wr_en) level_d = level_q - 1'b1;
        drop_cnt_d = drop_cnt_q;
        if (drop_clr_i)                    drop_cnt_d = drop ? CNT_BITS'(1) : '0;
        else if (drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
        busy_ctr_d = busy_ctr_q;
        if (!busy)                  busy_ctr_d = BUSY_LOAD;
        else if (busy_ctr_q != '0)  busy_ctr_d = busy_ctr_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= mpkt.data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dump_mode_q <= 1'b0;
            busy_ctr_q  <= BUSY_LOAD;
            exit_ctr_q  <= '0;
        end else begin
            busy_ctr_q <= busy_ctr_d;
            case (state_q)
                IDLE: begin
                    if (busy && busy_ctr_q == '0) begin
                        state_q     <= DUMP;
                        dump_mode_q <= 1'b1;
                        exit_ctr_q  <= '0;
                    end
                end
                DUMP: begin
                    // Exit hysteresis: only an unbroken run of EXIT_CNT idle cycles leaves dump.
                    if (busy) begin
                        exit_ctr_q <= '0;
                    end else if (exit_ctr_q == EXIT_LAST) begin
                        state_q     <= IDLE;
                        dump_mode_q <= 1'b0;
                        exit_ctr_q  <= '0;
                    end else begin
                        exit_ctr_q <= exit_ctr_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    dump_mode_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spinn_aer_if_dump_buf.sv
// Scoreboard bench for spinn_aer_if_dump_buf. The main instance uses EXIT_CNT=4, and a
// second instance with CNT_BITS=4 shares the same stimulus for the drop-counter saturation test.
module tb_spinn_aer_if_dump_buf;
    logic        clk = 1'b0;
    logic        rst, go, drop_clr, mvld, irdy;
    logic [71:0] mdata;
    logic [71:0] sb[$];
    logic [71:0] exp_pkt;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic        dump1, dump2;
    logic [15:0] dcnt1;
    logic [3:0]  dcnt2;
    logic [2:0]  lvl1, lvl2;

    spinn_aer_if_dump_buf_if #(.PKT_BITS(72)) m1 ();
    spinn_aer_if_dump_buf_if #(.PKT_BITS(72)) i1 ();
    spinn_aer_if_dump_buf_if #(.PKT_BITS(72)) m2 ();
    spinn_aer_if_dump_buf_if #(.PKT_BITS(72)) i2 ();

    assign m1.data = mdata;
    assign m1.vld  = mvld;
    assign i1.rdy  = irdy;
    assign m2.data = mdata;
    assign m2.vld  = mvld;
    assign i2.rdy  = irdy;

    spinn_aer_if_dump_buf #(
        .PKT_BITS(72), .FIFO_ADDR_BITS(2), .DUMP_CNT(31), .EXIT_CNT(4), .CNT_BITS(16)
    ) dut (
        .clk(clk), .rst(rst), .go_i(go), .drop_clr_i(drop_clr), .dump_mode_o(dump1),
        .drop_cnt_o(dcnt1), .fifo_level_o(lvl1), .mpkt(m1), .ipkt(i1)
    );

    spinn_aer_if_dump_buf #(
        .PKT_BITS(72), .FIFO_ADDR_BITS(2), .DUMP_CNT(31), .EXIT_CNT(4), .CNT_BITS(4)
    ) dut_sat (
        .clk(clk), .rst(rst), .go_i(go), .drop_clr_i(drop_clr), .dump_mode_o(dump2),
        .drop_cnt_o(dcnt2), .fifo_level_o(lvl2), .mpkt(m2), .ipkt(i2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Each transfer that the next edge will perform is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && i1.vld && irdy) begin
            exp_pkt = (sb.size() > 0) ? sb.pop_front() : '1;
            chk("ipkt_data", 128'(i1.data), 128'(exp_pkt));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; go = 1'b1; drop_clr = 1'b0; mvld = 1'b0; irdy = 1'b0; mdata = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_dump", 128'(dump1), 128'(0));
        chk("rst_level", 128'(lvl1), 128'(0));
        chk("rst_ivld", 128'(i1.vld), 128'(0));
        chk("rst_dcnt", 128'(dcnt1), 128'(0));
        chk("rst_mrdy", 128'(m1.rdy), 128'(1));

        // Pass-through: each packet is at the head one cycle after it is accepted.
        irdy = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            mdata = 72'(i); mvld = 1'b1; sb.push_back(72'(i));
            tick();
            chk("t1_ivld", 128'(i1.vld), 128'(1));
            chk("t1_head", 128'(i1.data), 128'(i));
            chk("t1_dump", 128'(dump1), 128'(0));
        end
        mvld = 1'b0;
        tick(); tick();
        chk("t1_dcnt", 128'(dcnt1), 128'(0));
        chk("t1_level", 128'(lvl1), 128'(0));

        // Stall: fill the FIFO, then dump after 32 busy cycles.
        irdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mdata = 72'h100 + 72'(i); mvld = 1'b1; sb.push_back(mdata);
            tick();
        end
        mvld = 1'b0;
        chk("t2_level", 128'(lvl1), 128'(4));
        chk("t2_mrdy_full", 128'(m1.rdy), 128'(0));
        repeat (28) tick();
        chk("t2_dump_early", 128'(dump1), 128'(0));
        tick();
        chk("t2_dump", 128'(dump1), 128'(1));
        chk("t2_mrdy_dump", 128'(m1.rdy), 128'(1));
        for (int i = 0; i < 5; i++) begin
            mdata = 72'h200 + 72'(i); mvld = 1'b1;
            tick();
        end
        mvld = 1'b0;
        chk("t2_dcnt", 128'(dcnt1), 128'(5));
        chk("t2_level_kept", 128'(lvl1), 128'(4));

        // Drain in dump mode with broken idle runs, then exit after 4 straight idle cycles.
        for (int i = 0; i < 4; i++) begin
            irdy = 1'b0; tick();
            chk("t4_hold_busy", 128'(dump1), 128'(1));
            irdy = 1'b1; tick();
            chk("t4_hold_pop", 128'(dump1), 128'(1));
        end
        chk("t3_drained", 128'(lvl1), 128'(0));
        tick();
        chk("t3_exit_2", 128'(dump1), 128'(1));
        tick();
        chk("t3_exit_3", 128'(dump1), 128'(1));
        tick();
        chk("t3_exit_4", 128'(dump1), 128'(0));

        // Exactly 31 busy cycles must not enter dump.
        irdy = 1'b0; mdata = 72'h3AA; mvld = 1'b1; sb.push_back(mdata);
        tick();
        mvld = 1'b0;
        repeat (31) tick();
        chk("t3_31busy", 128'(dump1), 128'(0));
        irdy = 1'b1;
        tick();
        chk("t3_31busy_rdy", 128'(dump1), 128'(0));
        chk("t3_sb_empty", 128'(sb.size()), 128'(0));

        // go=0 drops everything; the narrow counter saturates, and clear with a same-cycle drop gives 1.
        drop_clr = 1'b1; tick(); drop_clr = 1'b0;
        chk("t5_clr", 128'(dcnt1), 128'(0));
        go = 1'b0; #1;
        chk("t5_mrdy", 128'(m1.rdy), 128'(1));
        mvld = 1'b1;
        for (int i = 0; i < 7; i++) begin
            mdata = 72'h500 + 72'(i);
            tick();
        end
        chk("t5_dcnt7", 128'(dcnt1), 128'(7));
        chk("t5_level", 128'(lvl1), 128'(0));
        chk("t5_ivld", 128'(i1.vld), 128'(0));
        repeat (13) tick();
        chk("t5_dcnt20", 128'(dcnt1), 128'(20));
        chk("t5_sat", 128'(dcnt2), 128'(15));
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0; mvld = 1'b0;
        chk("t5_clr_drop", 128'(dcnt1), 128'(1));
        chk("t5_clr_drop_sat", 128'(dcnt2), 128'(1));
        go = 1'b1;

        // Reset in the middle of a dump with three packets held.
        irdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mdata = 72'h600 + 72'(i); mvld = 1'b1;
            tick();
        end
        mvld = 1'b0;
        repeat (30) tick();
        chk("t6_dump", 128'(dump1), 128'(1));
        chk("t6_level", 128'(lvl1), 128'(3));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_dump", 128'(dump1), 128'(0));
        chk("t6_rst_level", 128'(lvl1), 128'(0));
        chk("t6_rst_ivld", 128'(i1.vld), 128'(0));
        chk("t6_rst_dcnt", 128'(dcnt1), 128'(0));
        irdy = 1'b1; mdata = 72'hC3_0000_0000_0000_03C3; mvld = 1'b1; sb.push_back(mdata);
        tick();
        mvld = 1'b0;
        chk("t6_fwd_vld", 128'(i1.vld), 128'(1));
        chk("t6_fwd_head", 128'(i1.data), 128'(72'hC3_0000_0000_0000_03C3));
        tick();
        chk("t6_fwd_level", 128'(lvl1), 128'(0));
        chk("t6_sb_empty", 128'(sb.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
